instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit with a byte-loadable instruction memory.
// A debug loader fills the memory byte by byte. The unit then fetches
// big-endian 32-bit words into the IF/ID latch. Stall, single-step and
// jump redirect control the fetch, and fetching HALT_WORD stops the unit.
module instruction_fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] PC_RESET   = 32'h0,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load_en,
    input  logic        i_load_valid,
    input  logic [7:0]  i_load_byte,
    input  logic        i_run,
    input  logic        i_step_mode,
    input  logic        i_step,
    input  logic        i_stall,
    input  logic        i_jump,
    input  logic [31:0] i_jump_address,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_pc,
    output logic        o_load_done,
    output logic        o_halted,
    output logic [1:0]  o_state
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] WPTR_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] WPTR_LAST = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_READY  = 2'd1,
        ST_RUN    = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] wptr_q;
    logic [31:0]           pc_q;
    logic [31:0]           instr_q;
    logic [31:0]           pc_plus4_q;
    logic                  load_done_q;
    logic                  halted_q;
    logic [7:0]            mem_q [DEPTH];

    logic [ADDR_WIDTH-3:0] fetch_idx;
    logic [ADDR_WIDTH-3:0] load_idx;
    logic [31:0]           fetch_word;
    logic [31:0]           load_word;
    logic [31:0]           pc_plus4_d;
    logic [31:0]           jump_target;
    logic                  load_wr;
    logic                  load_last;
    logic                  advance;

    // Asynchronous big-endian word read. Upper PC bits are ignored, so
    // the fetch address wraps around the memory.
    assign fetch_idx  = pc_q[ADDR_WIDTH-1:2];
    assign fetch_word = {mem_q[{fetch_idx, 2'b00}], mem_q[{fetch_idx, 2'b01}],
                         mem_q[{fetch_idx, 2'b10}], mem_q[{fetch_idx, 2'b11}]};

    // Word that will exist once the byte being loaded is written.
    // This word is only meaningful when that byte is the last of an aligned word.
    assign load_idx  = wptr_q[ADDR_WIDTH-1:2];
    assign load_word = {mem_q[{load_idx, 2'b00}], mem_q[{load_idx, 2'b01}],
                        mem_q[{load_idx, 2'b10}], i_load_byte};

    assign load_wr   = (state_q == ST_LOAD) && i_load_valid;
    assign load_last = load_wr && (((wptr_q[1:0] == 2'b11) && (load_word == HALT_WORD))
                                   || (wptr_q == WPTR_LAST));

    assign advance     = !i_stall && (!i_step_mode || i_step);
    assign pc_plus4_d  = pc_q + 32'd4;
    assign jump_target = i_jump_address & 32'hFFFF_FFFC;

    // Byte write port, active only while loading and not in reset.
    always_ff @(posedge i_clk) begin
        // NOTE: memory is deliberately not reset; contents survive reset and partial reloads.
        if (i_reset && load_wr) begin
            mem_q[wptr_q] <= i_load_byte;
        end
    end

    // Control FSM with registered PC, IF/ID latch and status outputs.
    always_ff @(posedge i_clk) begin
        // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
        if (!i_reset) begin
            state_q     <= ST_LOAD;
            wptr_q      <= '0;
            pc_q        <= PC_RESET;
            instr_q     <= '0;
            pc_plus4_q  <= '0;
            load_done_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (load_wr) begin
                        wptr_q <= wptr_q + WPTR_ONE;
                        if (load_last) begin
                            state_q     <= ST_READY;
                            load_done_q <= 1'b1;
                            pc_q        <= PC_RESET;
                            instr_q     <= '0;
                        end
                    end
                end
                ST_READY: begin
                    if (i_load_en) begin
                        state_q     <= ST_LOAD;
                        wptr_q      <= '0;
                        load_done_q <= 1'b0;
                        pc_q        <= PC_RESET;
                        instr_q     <= '0;
                    end else if (i_run) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_jump) begin
                        // Redirect wins over stall/step and inserts a bubble.
                        pc_q    <= jump_target;
                        instr_q <= '0;
                    end else if (advance) begin
                        instr_q    <= fetch_word;
                        pc_plus4_q <= pc_plus4_d;
                        if (fetch_word == HALT_WORD) begin
                            state_q  <= ST_HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            pc_q <= pc_plus4_d;
                        end
                    end
                end
                ST_HALTED: begin
                    if (i_load_en) begin
                        state_q     <= ST_LOAD;
                        wptr_q      <= '0;
                        load_done_q <= 1'b0;
                        halted_q    <= 1'b0;
                        pc_q        <= PC_RESET;
                        instr_q     <= '0;
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign o_instruction = instr_q;
    assign o_pc_plus4    = pc_plus4_q;
    assign o_pc          = pc_q;
    assign o_load_done   = load_done_q;
    assign o_halted      = halted_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: a default-size instance runs a
// vector table plus reset/reload sequences; a 16-byte instance checks
// load wrap-around and address wrap.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-size instance
    logic        reset, load_en, load_valid, run, step_mode, step, stall, jump;
    logic [7:0]  load_byte;
    logic [31:0] jaddr, instr, pc4, pc;
    logic        load_done, halted;
    logic [1:0]  state;

    // 16-byte instance
    logic        w_reset, w_load_en, w_load_valid, w_run, w_step_mode, w_step, w_stall, w_jump;
    logic [7:0]  w_load_byte;
    logic [31:0] w_jaddr, w_instr, w_pc4, w_pc;
    logic        w_load_done, w_halted;
    logic [1:0]  w_state;

    instruction_fetch_unit u_dut (
        .i_clk(clk), .i_reset(reset), .i_load_en(load_en), .i_load_valid(load_valid),
        .i_load_byte(load_byte), .i_run(run), .i_step_mode(step_mode), .i_step(step),
        .i_stall(stall), .i_jump(jump), .i_jump_address(jaddr),
        .o_instruction(instr), .o_pc_plus4(pc4), .o_pc(pc),
        .o_load_done(load_done), .o_halted(halted), .o_state(state)
    );

    instruction_fetch_unit #(.ADDR_WIDTH(4)) u_dut4 (
        .i_clk(clk), .i_reset(w_reset), .i_load_en(w_load_en), .i_load_valid(w_load_valid),
        .i_load_byte(w_load_byte), .i_run(w_run), .i_step_mode(w_step_mode), .i_step(w_step),
        .i_stall(w_stall), .i_jump(w_jump), .i_jump_address(w_jaddr),
        .o_instruction(w_instr), .o_pc_plus4(w_pc4), .o_pc(w_pc),
        .o_load_done(w_load_done), .o_halted(w_halted), .o_state(w_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [1:0] e_st, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic [31:0] e_pc4,
                              input logic chk4, input logic e_halt);
        check({tag, " state"}, 32'(state), 32'(e_st));
        check({tag, " pc"}, pc, e_pc);
        check({tag, " instr"}, instr, e_instr);
        if (chk4) check({tag, " pc_plus4"}, pc4, e_pc4);
        check({tag, " load_done"}, 32'(load_done), 32'(e_st != 2'd0));
        check({tag, " halted"}, 32'(halted), 32'(e_halt));
    endtask

    task automatic check_w4(input string tag, input logic [1:0] e_st, input logic [31:0] e_pc,
                            input logic [31:0] e_instr, input logic [31:0] e_pc4);
        check({tag, " state"}, 32'(w_state), 32'(e_st));
        check({tag, " pc"}, w_pc, e_pc);
        check({tag, " instr"}, w_instr, e_instr);
        check({tag, " pc_plus4"}, w_pc4, e_pc4);
    endtask

    task automatic load_byte_main(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic load_word_main(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) load_byte_main(w[8*k +: 8]);
    endtask

    task automatic load_byte_w4(input logic [7:0] b);
        w_load_valid = 1'b1;
        w_load_byte  = b;
        tick();
        w_load_valid = 1'b0;
    endtask

    typedef struct {
        logic        run, stall, step_mode, step, jump, load_en;
        logic [31:0] jaddr;
        logic [1:0]  st;
        logic [31:0] pc, instr, pc4;
        logic        chk4, halted;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic sm, input logic sp,
                                input logic j, input logic [31:0] ja, input logic le,
                                input logic [1:0] st, input logic [31:0] e_pc,
                                input logic [31:0] e_instr, input logic [31:0] e_pc4,
                                input logic c4, input logic h);
        vec_t v;
        v.run = r; v.stall = s; v.step_mode = sm; v.step = sp; v.jump = j; v.jaddr = ja;
        v.load_en = le; v.st = st; v.pc = e_pc; v.instr = e_instr; v.pc4 = e_pc4;
        v.chk4 = c4; v.halted = h;
        return v;
    endfunction

    vec_t vecs[18];

    initial begin
        // Program 00000001 / 00000002 / FFFFFFFF already in memory, unit in READY at PC 0.
        //             run st sm sp j  jaddr      le  st  pc        instr         pc4   c4 h
        vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,     0, 2, 32'h0,  32'h0,        32'd0,  1, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 32'h0,     0, 2, 32'h4,  32'h1,        32'd4,  1, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 32'h0,     0, 2, 32'h4,  32'h1,        32'd4,  1, 0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 32'h0,     0, 2, 32'h4,  32'h1,        32'd4,  1, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0, 32'h0,     0, 2, 32'h4,  32'h1,        32'd4,  1, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 32'h0,     0, 2, 32'h8,  32'h2,        32'd8,  1, 0);
        vecs[6]  = mk(0, 1, 0, 0, 1, 32'h13,    0, 2, 32'h10, 32'h0,        32'd8,  1, 0);
        vecs[7]  = mk(0, 0, 0, 0, 1, 32'h2,     0, 2, 32'h0,  32'h0,        32'd8,  1, 0);
        vecs[8]  = mk(0, 0, 1, 0, 0, 32'h0,     0, 2, 32'h0,  32'h0,        32'd8,  1, 0);
        vecs[9]  = mk(0, 0, 1, 1, 0, 32'h0,     0, 2, 32'h4,  32'h1,        32'd4,  1, 0);
        vecs[10] = mk(0, 0, 1, 0, 0, 32'h0,     0, 2, 32'h4,  32'h1,        32'd4,  1, 0);
        vecs[11] = mk(0, 0, 1, 0, 0, 32'h0,     0, 2, 32'h4,  32'h1,        32'd4,  1, 0);
        vecs[12] = mk(0, 0, 1, 0, 0, 32'h0,     0, 2, 32'h4,  32'h1,        32'd4,  1, 0);
        vecs[13] = mk(0, 0, 1, 0, 0, 32'h0,     0, 2, 32'h4,  32'h1,        32'd4,  1, 0);
        vecs[14] = mk(0, 0, 1, 1, 0, 32'h0,     0, 2, 32'h8,  32'h2,        32'd8,  1, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 32'h0,     0, 3, 32'h8,  32'hFFFF_FFFF, 32'd12, 1, 1);
        vecs[16] = mk(1, 0, 0, 0, 1, 32'h40,    0, 3, 32'h8,  32'hFFFF_FFFF, 32'd12, 1, 1);
        vecs[17] = mk(1, 0, 0, 0, 0, 32'h0,     1, 0, 32'h0,  32'h0,        32'd0,  0, 0);

        reset = 1'b0; load_en = 1'b0; load_valid = 1'b0; load_byte = 8'h0; run = 1'b0;
        step_mode = 1'b0; step = 1'b0; stall = 1'b0; jump = 1'b0; jaddr = 32'h0;
        w_reset = 1'b0; w_load_en = 1'b0; w_load_valid = 1'b0; w_load_byte = 8'h0; w_run = 1'b0;
        w_step_mode = 1'b0; w_step = 1'b0; w_stall = 1'b0; w_jump = 1'b0; w_jaddr = 32'h0;

        // Reset values
        tick();
        check_main("reset", 2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_w4("w4 reset", 2'd0, 32'h0, 32'h0, 32'h0);
        reset = 1'b1;
        w_reset = 1'b1;

        // Load program; the halt word ends loading only after its 4th byte
        load_word_main(32'h0000_0001);
        load_word_main(32'h0000_0002);
        load_byte_main(8'hFF);
        load_byte_main(8'hFF);
        load_byte_main(8'hFF);
        check("load 11 bytes state", 32'(state), 32'd0);
        load_byte_main(8'hFF);
        check_main("load done", 2'd1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check("ready idle state", 32'(state), 32'd1);

        // Table-driven run: stall, jump, single step, halt, reload request
        for (int i = 0; i < 18; i++) begin
            run = vecs[i].run; stall = vecs[i].stall; step_mode = vecs[i].step_mode;
            step = vecs[i].step; jump = vecs[i].jump; jaddr = vecs[i].jaddr;
            load_en = vecs[i].load_en;
            tick();
            check_main($sformatf("v%0d", i), vecs[i].st, vecs[i].pc, vecs[i].instr,
                       vecs[i].pc4, vecs[i].chk4, vecs[i].halted);
        end
        run = 1'b0; stall = 1'b0; step_mode = 1'b0; step = 1'b0; jump = 1'b0; load_en = 1'b0;

        // Reload, run to PC 8, then reset mid-run
        load_word_main(32'h0000_0001);
        load_word_main(32'h0000_0002);
        load_word_main(32'hFFFF_FFFF);
        check("reload state", 32'(state), 32'd1);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        check("pre-reset pc", pc, 32'h8);
        reset = 1'b0;
        tick();
        check_main("mid-run reset", 2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        reset = 1'b1;

        // Short reload; load request beats run in READY
        load_word_main(32'hFFFF_FFFF);
        check("short load state", 32'(state), 32'd1);
        load_en = 1'b1;
        run = 1'b1;
        tick();
        load_en = 1'b0;
        run = 1'b0;
        check("load_en priority state", 32'(state), 32'd0);
        check("load_en priority load_done", 32'(load_done), 32'd0);
        load_word_main(32'hFFFF_FFFF);

        // Old bytes at address 4 survive; stray load bytes outside LOAD are ignored
        load_valid = 1'b1;
        load_byte  = 8'hAA;
        run = 1'b1;
        tick();
        run = 1'b0;
        check("rerun state", 32'(state), 32'd2);
        jump = 1'b1;
        jaddr = 32'h4;
        tick();
        jump = 1'b0;
        check_main("jump to 4", 2'd2, 32'h4, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        load_valid = 1'b0;
        check_main("old word at 4", 2'd2, 32'h8, 32'h2, 32'h8, 1'b1, 1'b0);

        // 16-byte memory: fill completely, leave LOAD through pointer wrap
        for (int i = 0; i < 15; i++) load_byte_w4(8'(8'h10 + i));
        check("w4 15 bytes state", 32'(w_state), 32'd0);
        load_byte_w4(8'h1F);
        check_w4("w4 full", 2'd1, 32'h0, 32'h0, 32'h0);
        check("w4 load_done", 32'(w_load_done), 32'd1);
        w_run = 1'b1;
        tick();
        w_run = 1'b0;
        check("w4 run state", 32'(w_state), 32'd2);
        tick();
        check_w4("w4 f0", 2'd2, 32'd4, 32'h1011_1213, 32'd4);
        tick();
        check_w4("w4 f1", 2'd2, 32'd8, 32'h1415_1617, 32'd8);
        tick();
        check_w4("w4 f2", 2'd2, 32'd12, 32'h1819_1A1B, 32'd12);
        tick();
        check_w4("w4 f3", 2'd2, 32'd16, 32'h1C1D_1E1F, 32'd16);
        tick();
        check_w4("w4 wrap fetch", 2'd2, 32'd20, 32'h1011_1213, 32'd20);
        w_jump = 1'b1;
        w_jaddr = 32'hFFFF_FFFE;
        tick();
        w_jump = 1'b0;
        check_w4("w4 jump top", 2'd2, 32'hFFFF_FFFC, 32'h0, 32'd20);
        tick();
        check_w4("w4 pc modulo", 2'd2, 32'h0, 32'h1C1D_1E1F, 32'h0);
        check("w4 halted", 32'(w_halted), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
